// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle between the setpoint entry logic (master) and the
// BCD-to-binary converter (slave), plus a debug view of the converter FSM.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 12
);
  // Handshake: the master raises start with bcd_in valid; the converter takes it
  // only while busy=0 (IDLE). While busy=1, start is ignored and nothing is
  // queued. done pulses for one cycle once the result is registered. bin_out, err
  // and ovf are valid from done until the next done.
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  logic                  ovf;
  logic [1:0]            dbg_state;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err, ovf, dbg_state
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err, ovf, dbg_state
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: validates all digits, then
// multiply-accumulates one digit per clock (MSD first) and saturates to 2^BIN_W-1.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 12
) (
  input  logic            CLOCK_50,
  input  logic            resetn,
  bcd_to_bin_seq_if.slave bus
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = ((SW > BIN_W) ? SW : BIN_W) + 1;

  localparam logic [BIN_W-1:0] MAX_VAL = {BIN_W{1'b1}};
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [SW-1:0]      sh;
  logic [SW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               done;
  logic [BIN_W-1:0]   bin_out;
  logic               err;
  logic               ovf;

  logic               digit_bad;
  logic [SW-1:0]      acc_next;
  logic [EXT_W-1:0]   acc_ext;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // acc*10 + next digit; acc never exceeds 10^DIGITS-1, so SW bits suffice.
  assign acc_next = (acc << 3) + (acc << 1) + SW'(sh[SW-1 -: 4]);
  assign acc_ext  = EXT_W'(acc_next);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      sh      <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            sh    <= bus.bcd_in;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (digit_bad) begin
            err     <= 1'b1;
            ovf     <= 1'b0;
            bin_out <= '0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= CONV;
          end
        end

        CONV: begin
          acc <= acc_next;
          sh  <= sh << 4;
          cnt <= cnt + 1'b1;
          // Result is registered on the same edge that consumes the last digit.
          if (cnt == LAST) begin
            done  <= 1'b1;
            err   <= 1'b0;
            state <= DONE;
            if (acc_ext > MAX_EXT) begin
              ovf     <= 1'b1;
              bin_out <= MAX_VAL;
            end else begin
              ovf     <= 1'b0;
              bin_out <= acc_ext[BIN_W-1:0];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.bin_out   = bin_out;
  assign bus.err       = err;
  assign bus.ovf       = ovf;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq (DIGITS=4, BIN_W=12) against
// an arithmetic reference model and an expected-result queue.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 12;
  localparam int LAT_OK  = DIGITS + 1;
  localparam int LAT_ERR = 1;

  logic CLOCK_50;
  logic resetn;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // {err, ovf, bin_out}
  logic [BIN_W+1:0] exp_q[$];
  logic [BIN_W+1:0] prev_res;

  // ---------------- clock / reset ----------------
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [BIN_W+1:0] model(input logic [4*DIGITS-1:0] bcd);
    int value;
    int place;
    int d;
    bit bad;
    value = 0;
    place = 1;
    bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((bcd >> (4 * i)) & 16'hF);
      if (d > 9) bad = 1'b1;
      value += d * place;
      place *= 10;
    end
    if (bad) return {2'b10, {BIN_W{1'b0}}};
    if (value > (1 << BIN_W) - 1) return {2'b01, {BIN_W{1'b1}}};
    return {2'b00, BIN_W'(value)};
  endfunction

  function automatic logic [BIN_W+1:0] observed();
    return {bus.err, bus.ovf, bus.bin_out};
  endfunction

  // ---------------- driver: one full conversion ----------------
  task automatic run_conv(input logic [4*DIGITS-1:0] bcd, input bit scramble, input string name);
    logic [BIN_W+1:0] exp;
    int edges;
    int lat;
    bit busy_ok;
    bit hold_ok;
    exp_q.push_back(model(bcd));
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    edges   = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && edges < 20) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (observed() !== prev_res) hold_ok = 1'b0;
      if (scramble) bus.bcd_in = 16'($urandom);
      tick();
      edges++;
    end
    exp = exp_q.pop_front();
    lat = exp[BIN_W+1] ? LAT_ERR : LAT_OK;

    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d edges (bcd=%h)", name, edges, bcd);
    end
    checks++;
    if (edges != lat) begin
      errors++;
      $display("FAIL %s latency: done after edge %0d, expected edge %0d (bcd=%h)", name, edges, lat, bcd);
    end
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL %s result: got err/ovf/bin=%h expected %h (bcd=%h)", name, observed(), exp, bcd);
    end
    checks++;
    if (!busy_ok || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: busy dropped during conversion, got %b expected 1 (bcd=%h)", name, bus.busy, bcd);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s hold: outputs changed before done, expected %h held (bcd=%h)", name, prev_res, bcd);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, bus.done, bus.busy);
    end
    prev_res = exp;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn     = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/err/ovf=%b expected 0000", {bus.busy, bus.done, bus.err, bus.ovf});
    end
    checks++;
    if (bus.bin_out !== '0) begin
      errors++;
      $display("FAIL reset_bin: got %h expected 000", bus.bin_out);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    prev_res = '0;
  endtask

  task automatic test_directed();
    logic [15:0] vec[8] = '{16'h4095, 16'h4096, 16'h9999, 16'h12A4,
                            16'h0815, 16'h0000, 16'h1000, 16'h0007};
    for (int i = 0; i < 8; i++) run_conv(vec[i], 1'b0, $sformatf("directed_%h", vec[i]));
    checks++;
    if (bus.bin_out !== 12'd7) begin
      errors++;
      $display("FAIL directed_const: got %0d expected 7", bus.bin_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] bcd;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < DIGITS; i++) bcd[4*i +: 4] = 4'($urandom_range(0, 9));
      end else begin
        bcd = 16'($urandom);
      end
      run_conv(bcd, 1'b1, "random");
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    int dones;
    bus.bcd_in = 16'h0123;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0999;
    tick();
    bus.start  = 1'b0;
    bus.bcd_in = 16'h5555;
    edges = 3;
    dones = 0;
    while (bus.done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != LAT_OK || bus.bin_out !== 12'd123 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: done at edge %0d bin=%0d err=%b expected edge %0d bin=123 err=0",
               edges, bus.bin_out, bus.err, LAT_OK);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL ignore_start_extra: got %0d busy/done cycles after result expected 0", dones);
    end
    prev_res = {2'b00, 12'd123};
  endtask

  task automatic test_back_to_back();
    int done_edges[$];
    int idle_seen;
    bus.bcd_in = 16'h0321;
    bus.start  = 1'b1;
    tick();
    idle_seen = 0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (bus.done === 1'b1) done_edges.push_back(e);
      if (bus.busy === 1'b0) idle_seen++;
    end
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (done_edges.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones expected 3", done_edges.size());
    end else begin
      checks++;
      if (done_edges[0] != 5 || done_edges[1] != 12 || done_edges[2] != 19) begin
        errors++;
        $display("FAIL b2b_spacing: got edges %0d,%0d,%0d expected 5,12,19",
                 done_edges[0], done_edges[1], done_edges[2]);
      end
    end
    checks++;
    if (idle_seen != 2 || bus.busy !== 1'b0 || bus.bin_out !== 12'd321) begin
      errors++;
      $display("FAIL b2b_idle: got idle=%0d busy=%b bin=%0d expected idle=2 busy=0 bin=321",
               idle_seen, bus.busy, bus.bin_out);
    end
    prev_res = {2'b00, 12'd321};
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.bcd_in = 16'h2048;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.ovf, bus.bin_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy/done/err/ovf/bin=%b/%b/%b/%b/%h expected all 0",
               bus.busy, bus.done, bus.err, bus.ovf, bus.bin_out);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d done pulses expected 0", dones);
    end
    prev_res = '0;
    run_conv(16'h2048, 1'b0, "after_reset_2048");
    checks++;
    if (bus.bin_out !== 12'h800) begin
      errors++;
      $display("FAIL after_reset_const: got %h expected 800", bus.bin_out);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
